// File: rtl/dlatch_chk_pkg.sv
// Shared types and default sizing for the gated D latch response checker.
package dlatch_chk_pkg;

    // Checker sequencing states; encoding kept stable for debug probes.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_CHECK    = 3'd2,
        ST_WAIT_CHG = 3'd3,
        ST_DONE     = 3'd4
    } chk_state_t;

    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_MAX_VECTORS   = 32;
    localparam int DEF_CNT_W         = 8;

    // A run is in progress while the checker is settling, checking or waiting.
    function automatic logic state_is_busy(input chk_state_t st);
        logic result;
        case (st)
            ST_SETTLE:   result = 1'b1;
            ST_CHECK:    result = 1'b1;
            ST_WAIT_CHG: result = 1'b1;
            ST_IDLE:     result = 1'b0;
            ST_DONE:     result = 1'b0;
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dlatch_checker_sync.sv
// Two-flop synchronizer bank for the asynchronous latch stimulus/response pins.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Capture the asynchronous inputs and let metastability resolve in the first stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
        end
    end

    assign synced = sync_r;

endmodule

// File: rtl/dlatch_checker.sv
// Response checker for the gated D latch lab circuit: waits for each stimulus
// vector to settle, compares the latch outputs against a registered golden
// model and reports vector/error counts and pass/done status.
module dlatch_checker
    import dlatch_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_VECTORS   = DEF_MAX_VECTORS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             G,
    input  logic             D,
    input  logic             Q,
    input  logic             Q1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic             compl_err
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_ONE     = SET_W'(1);
    localparam logic [CNT_W-1:0] VEC_LIMIT   = CNT_W'(MAX_VECTORS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Saturating increment so the error counter never wraps back to a passing value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // Synchronized view of the pins; nothing below touches the raw inputs.
    logic [3:0] sync_bus_s;
    logic       gs_s;
    logic       ds_s;
    logic       qs_s;
    logic       q1s_s;
    logic [1:0] stim_s;
    logic       changed_s;

    // Golden model evaluation for the current (settled) vector.
    logic       exp_bit_s;
    logic       valid_s;
    logic       compl_hit_s;
    logic       mismatch_s;
    logic [CNT_W-1:0] vec_inc_s;

    // Sequencing and datapath state.
    chk_state_t       state_r;
    chk_state_t       state_next_s;
    logic [SET_W-1:0] cnt_r;
    logic [SET_W-1:0] cnt_next_s;
    logic [1:0]       prev_r;
    logic [1:0]       prev_next_s;
    logic             exp_q_r;
    logic             exp_q_next_s;
    logic             exp_valid_r;
    logic             exp_valid_next_s;
    logic [CNT_W-1:0] err_r;
    logic [CNT_W-1:0] err_next_s;
    logic [CNT_W-1:0] vec_r;
    logic [CNT_W-1:0] vec_next_s;
    logic             compl_r;
    logic             compl_next_s;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;

    sync_2ff #(
        .WIDTH (4)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .raw    ({G, D, Q, Q1}),
        .synced (sync_bus_s)
    );

    assign {gs_s, ds_s, qs_s, q1s_s} = sync_bus_s;
    assign stim_s      = {gs_s, ds_s};
    assign changed_s   = (stim_s != prev_r);

    // Before the latch has ever been opened its output is unknown, so only the
    // complement relation is checked until a G=1 vector has been seen.
    assign exp_bit_s   = gs_s ? ds_s : exp_q_r;
    assign valid_s     = gs_s | exp_valid_r;
    assign compl_hit_s = (qs_s == q1s_s);
    assign mismatch_s  = (valid_s && (qs_s != exp_bit_s)) || compl_hit_s;
    assign vec_inc_s   = vec_r + CNT_ONE;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: settle on a stable vector, check it once, then wait for a new one.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_SETTLE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (changed_s) begin
                    state_next_s = ST_SETTLE;
                end else if (cnt_r == SETTLE_LAST) begin
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (vec_inc_s == VEC_LIMIT) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT_CHG;
                end
            end
            ST_WAIT_CHG: begin
                if (changed_s) begin
                    state_next_s = ST_SETTLE;
                end else begin
                    state_next_s = ST_WAIT_CHG;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next_s = ST_SETTLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath updates per state: run clear on start, settle counter, golden model and counters.
    always_comb begin
        cnt_next_s       = cnt_r;
        prev_next_s      = prev_r;
        exp_q_next_s     = exp_q_r;
        exp_valid_next_s = exp_valid_r;
        err_next_s       = err_r;
        vec_next_s       = vec_r;
        compl_next_s     = compl_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_next_s       = '0;
                    vec_next_s       = '0;
                    compl_next_s     = 1'b0;
                    exp_valid_next_s = 1'b0;
                    prev_next_s      = stim_s;
                    cnt_next_s       = '0;
                end else begin
                    cnt_next_s       = cnt_r;
                end
            end
            ST_SETTLE: begin
                if (changed_s) begin
                    prev_next_s = stim_s;
                    cnt_next_s  = '0;
                end else if (cnt_r == SETTLE_LAST) begin
                    cnt_next_s  = cnt_r;
                end else begin
                    cnt_next_s  = cnt_r + SET_ONE;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    err_next_s = sat_inc(err_r);
                end else begin
                    err_next_s = err_r;
                end
                if (compl_hit_s) begin
                    compl_next_s = 1'b1;
                end else begin
                    compl_next_s = compl_r;
                end
                if (gs_s) begin
                    exp_q_next_s     = ds_s;
                    exp_valid_next_s = 1'b1;
                end else begin
                    exp_q_next_s     = exp_q_r;
                    exp_valid_next_s = exp_valid_r;
                end
                vec_next_s = vec_inc_s;
            end
            ST_WAIT_CHG: begin
                if (changed_s) begin
                    prev_next_s = stim_s;
                    cnt_next_s  = '0;
                end else begin
                    cnt_next_s  = cnt_r;
                end
            end
            default: begin
                cnt_next_s = cnt_r;
            end
        endcase
    end

    // Datapath registers and registered status outputs, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= '0;
            prev_r      <= 2'b00;
            exp_q_r     <= 1'b0;
            exp_valid_r <= 1'b0;
            err_r       <= '0;
            vec_r       <= '0;
            compl_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            cnt_r       <= cnt_next_s;
            prev_r      <= prev_next_s;
            exp_q_r     <= exp_q_next_s;
            exp_valid_r <= exp_valid_next_s;
            err_r       <= err_next_s;
            vec_r       <= vec_next_s;
            compl_r     <= compl_next_s;
            busy_r      <= state_is_busy(state_next_s);
            done_r      <= (state_next_s == ST_DONE);
            pass_r      <= (state_next_s == ST_DONE) && (err_next_s == '0) && !compl_next_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_r;
    assign vec_count = vec_r;
    assign compl_err = compl_r;

endmodule

// File: tb/tb_dlatch_checker.sv
// Directed scoreboard bench for dlatch_checker: a bench-side latch drives Q/Q1,
// a bench-side checker model predicts counts per vector into a queue, and each
// settled vector's DUT counts are popped and compared.
module tb_dlatch_checker;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start2;
    logic       G;
    logic       D;
    logic       Q;
    logic       Q1;
    logic       Q_b;
    logic       Q1_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] vec_count;
    logic       compl_err;
    logic       busy2;
    logic       done2;
    logic       pass2;
    logic [1:0] err2;
    logic [1:0] vec2;
    logic       compl2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int vec;
        int err;
        int compl;
    } sb_t;
    sb_t sb[$];

    // Bench-side latch and checker model
    logic lat;
    int   mode;
    logic m_exp_q;
    logic m_valid;
    int   m_err;
    int   m_vec;
    int   m_compl;

    dlatch_checker #(
        .SETTLE_CYCLES (4),
        .MAX_VECTORS   (32),
        .CNT_W         (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .G         (G),
        .D         (D),
        .Q         (Q),
        .Q1        (Q1),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .vec_count (vec_count),
        .compl_err (compl_err)
    );

    dlatch_checker #(
        .SETTLE_CYCLES (4),
        .MAX_VECTORS   (3),
        .CNT_W         (2)
    ) dut_small (
        .clk       (clk),
        .reset     (reset),
        .start     (start2),
        .G         (G),
        .D         (D),
        .Q         (Q_b),
        .Q1        (Q1_b),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .err_count (err2),
        .vec_count (vec2),
        .compl_err (compl2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive one stimulus vector; Q/Q1 come from the bench latch according to mode.
    task automatic set_stim(input logic g, input logic d, input int idx);
        G = g;
        D = d;
        if (g) lat = d;
        case (mode)
            1: begin Q = 1'b0; Q1 = 1'b1; end
            2: begin Q = lat;  Q1 = (idx == 7) ? lat : ~lat; end
            default: begin Q = lat; Q1 = ~lat; end
        endcase
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_err   = 0;
        m_vec   = 0;
        m_compl = 0;
        sb.delete();
    endtask

    // Predict the checker's counts after this vector is checked and queue them.
    task automatic model_vec(input logic g, input logic d, input logic q, input logic q1,
                             input int max_err);
        logic e;
        logic v;
        logic mm;
        sb_t  item;
        e  = g ? d : m_exp_q;
        v  = g | m_valid;
        mm = (v && (q != e)) || (q == q1);
        if (mm && (m_err < max_err)) m_err++;
        if (q == q1) m_compl = 1;
        if (g) begin
            m_exp_q = d;
            m_valid = 1'b1;
        end
        m_vec++;
        item.vec   = m_vec;
        item.err   = m_err;
        item.compl = m_compl;
        sb.push_back(item);
    endtask

    task automatic sb_cmp(input string tag, input logic [31:0] v, input logic [31:0] e,
                          input logic [31:0] c);
        sb_t item;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=%0d expected=entry", tag, v);
        end else begin
            item = sb.pop_front();
            chk({tag, "_vec"}, v, item.vec);
            chk({tag, "_err"}, e, item.err);
            chk({tag, "_compl"}, c, item.compl);
        end
    endtask

    function automatic logic std_g(input int i);
        return ((i >= 6) && (i < 14)) || (i >= 24);
    endfunction

    task automatic drive_std(input int i);
        set_stim(std_g(i), ((i % 2) == 1), i);
        model_vec(G, D, Q, Q1, 255);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Full standard 32-vector run; every vector held 10 clk.
    task automatic run_std(input int mode_sel, input string tag);
        mode = mode_sel;
        model_clear();
        for (int i = 0; i < 32; i++) begin
            drive_std(i);
            if (i == 0) begin
                step(3);
                pulse_start();
                step(9);
            end else begin
                step(10);
            end
            sb_cmp(tag, 32'(vec_count), 32'(err_count), 32'(compl_err));
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        G      = 1'b0;
        D      = 1'b0;
        Q      = 1'b0;
        Q1     = 1'b1;
        Q_b    = 1'b1;
        Q1_b   = 1'b1;
        lat    = 1'b0;
        mode   = 0;
        m_exp_q = 1'b0;
        model_clear();
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_vec", 32'(vec_count), 0);
        chk("rst_compl", 32'(compl_err), 0);

        // 1: correct latch
        run_std(0, "t1");
        chk("t1_done", 32'(done), 1);
        chk("t1_pass", 32'(pass), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_vec", 32'(vec_count), 32);
        chk("t1_err", 32'(err_count), 0);
        chk("t1_compl", 32'(compl_err), 0);

        // 2: Q stuck 0, Q1 stuck 1
        run_std(1, "t2");
        chk("t2_done", 32'(done), 1);
        chk("t2_pass", 32'(pass), 0);
        chk("t2_err", 32'(err_count), 18);
        chk("t2_compl", 32'(compl_err), 0);

        // 3: Q1 equals Q on vector 7 only
        run_std(2, "t3");
        chk("t3_done", 32'(done), 1);
        chk("t3_pass", 32'(pass), 0);
        chk("t3_err", 32'(err_count), 1);
        chk("t3_compl", 32'(compl_err), 1);

        // 4: glitch mid-settle on vector 3, then 5: reset at vector 12
        mode = 1;
        model_clear();
        for (int i = 0; i < 12; i++) begin
            drive_std(i);
            if (i == 0) begin
                step(3);
                pulse_start();
                step(9);
            end else if (i == 3) begin
                step(3);
                set_stim(G, ~D, i);
                step(2);
                set_stim(std_g(i), ((i % 2) == 1), i);
                step(7);
                chk("glitch_not_yet", 32'(vec_count), 3);
                step(1);
                chk("glitch_once", 32'(vec_count), 4);
                step(2);
            end else begin
                step(10);
            end
            sb_cmp("t45", 32'(vec_count), 32'(err_count), 32'(compl_err));
        end
        chk("pre_rst_vec", 32'(vec_count), 12);
        chk("pre_rst_err", 32'(err_count), 3);
        chk("pre_rst_busy", 32'(busy), 1);
        set_stim(std_g(12), 1'b0, 12);
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        m_exp_q = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_err", 32'(err_count), 0);
        chk("mid_rst_vec", 32'(vec_count), 0);
        chk("mid_rst_compl", 32'(compl_err), 0);
        step(3);
        chk("idle_no_run", 32'(vec_count), 0);
        run_std(0, "t5");
        chk("t5_done", 32'(done), 1);
        chk("t5_pass", 32'(pass), 1);
        chk("t5_vec", 32'(vec_count), 32);

        // 6: small instance, every vector mismatches (Q==Q1), start while busy ignored
        model_clear();
        set_stim(1'b0, 1'b0, 0);
        model_vec(G, D, Q_b, Q1_b, 3);
        step(3);
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        step(9);
        sb_cmp("t6a", 32'(vec2), 32'(err2), 32'(compl2));
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        step(2);
        chk("busy_start_vec", 32'(vec2), 1);
        chk("busy_start_err", 32'(err2), 1);
        chk("busy_start_busy", 32'(busy2), 1);
        set_stim(1'b0, 1'b1, 1);
        model_vec(G, D, Q_b, Q1_b, 3);
        step(10);
        sb_cmp("t6b", 32'(vec2), 32'(err2), 32'(compl2));
        set_stim(1'b1, 1'b0, 2);
        model_vec(G, D, Q_b, Q1_b, 3);
        step(10);
        sb_cmp("t6c", 32'(vec2), 32'(err2), 32'(compl2));
        chk("t6_sat_err", 32'(err2), 3);
        chk("t6_done", 32'(done2), 1);
        chk("t6_pass", 32'(pass2), 0);
        chk("t6_busy", 32'(busy2), 0);
        set_stim(1'b1, 1'b1, 3);
        step(10);
        chk("t6_hold_vec", 32'(vec2), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dlatch_checker.md
Name: dlatch_checker

Overview:
- Synthesizable on-FPGA response checker for the gated D latch lab circuit; it is the observing end of the latch stimulus interface.
- Watches the stimulus pair (G, D) and the latch outputs (Q, Q1), and keeps a registered golden latch model.
- Compares the DUT against the model once per settled stimulus vector.
- Reports the vector count, error count, a sticky complement-violation flag and pass/done to the board LEDs/display.

Parameters:
SETTLE_CYCLES, 4, clk cycles the synchronized {G,D} must stay stable before a vector is checked (>=1)
MAX_VECTORS, 32, vectors per run; run ends after this many checks
CNT_W, 8, width of err_count and vec_count; must hold MAX_VECTORS

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin a run (one-cycle pulse or level; sampled only when not busy)
G  in  1  latch gate stimulus (asynchronous to clk)
D  in  1  latch data stimulus (asynchronous)
Q  in  1  DUT latch output (asynchronous)
Q1  in  1  DUT complementary output (asynchronous)
busy  out  1  run in progress
done  out  1  run complete; held until next start or reset
pass  out  1  done && err_count==0 && !compl_err
err_count  out  CNT_W  mismatching vectors, saturating at all-ones
vec_count  out  CNT_W  vectors checked this run
compl_err  out  1  sticky: Q==Q1 seen at some check

Behaviour:
- Reset: all outputs 0, state IDLE, exp_q=0, exp_valid=0, synchronizer stages 0.
- Synchronizer: G, D, Q and Q1 each pass through 2 flops before any use. All state logic sees only the synchronized signals Gs, Ds, Qs and Q1s, which adds 2 cycles of latency.
- State IDLE: busy=0. On start=1, clear err_count, vec_count, compl_err, exp_valid and done; set prev={Gs,Ds} and cnt=0; go to SETTLE. The current input counts as the first vector.
- State SETTLE: busy=1.
  - If {Gs,Ds}!=prev, set prev={Gs,Ds}, cnt=0 and stay in SETTLE. This makes the block glitch tolerant.
  - Otherwise, when cnt==SETTLE_CYCLES-1, go to CHECK; else cnt++.
- State CHECK (exactly one cycle):
  - Compute exp = Gs ? Ds : exp_q and valid = Gs | exp_valid.
  - mismatch = (valid && Qs!=exp) || (Qs==Q1s).
  - If mismatch, err_count++ (saturating). This is at most one increment per vector.
  - If Qs==Q1s, set compl_err=1.
  - If Gs, set exp_q=Ds and exp_valid=1.
  - vec_count++.
  - If the new vec_count==MAX_VECTORS, go to DONE; else go to WAIT_CHG.
- State WAIT_CHG: busy=1. On {Gs,Ds}!=prev, set prev={Gs,Ds}, cnt=0 and go to SETTLE. A stimulus that does not change is never re-checked.
- State DONE: busy=0, done=1; err_count and vec_count hold. start=1 behaves as in IDLE.
- start while busy is ignored.
- Reset has priority over everything. Reset mid-run forces the reset state on the next edge, with no residual counts.
- Output Q states before the first G=1 sample are not value-checked; only the complement check applies.

Decomposition:
- Package dlatch_chk_pkg holds:
  - state enum {IDLE, SETTLE, CHECK, WAIT_CHG, DONE}, 3 bits
  - default constants for SETTLE_CYCLES, MAX_VECTORS and CNT_W
- Sub-module sync_2ff: parameter WIDTH (4 here), clk/reset, 2-stage synchronizer with synchronous active-high reset to 0.
- FSM, golden model and counters stay in dlatch_checker.

Test Plan:
1. Correct behavioural latch driven by the standard 32-vector sequence -> done=1, pass=1, vec_count=32, err_count=0, compl_err=0. The sequence is:
   - G=0 with D alternating 0/1 for 6 vectors
   - G=1 alternating for 8
   - G=0 alternating for 10
   - G=1 alternating for 8
   - each vector held 10 clk
2. Same sequence with DUT Q stuck at 0 and Q1 stuck at 1 -> err_count=18 (4+10+4), compl_err=0, pass=0, done=1.
3. Same sequence with Q1 forced equal to Q on vector 7 only -> compl_err=1, err_count=1, pass=0.
4. SETTLE_CYCLES=4: D pulses for 2 cycles then returns, mid-settle -> a single CHECK for the restored value; vec_count increments by exactly 1 after 4 stable cycles.
5. Assert reset at vector 12 of a run -> next cycle busy=0, done=0, err_count=0, vec_count=0, compl_err=0. A fresh start then completes normally with pass=1.
6. CNT_W=2, MAX_VECTORS=3, all vectors mismatching -> err_count saturates at 3. A start pulse during busy is ignored, with no counter clear.
